fetch_queue: RTL

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register. It owns the fetch PC, reads one instruction per cycle from the combinational instruction memory, and buffers up to DEPTH {instruction, PC+4} pairs. Decode drains the queue at its own rate. An EX-stage branch or jump redirect flushes the queue and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetchq_storage.sv | 25 ++
 rtl/fetch_queue.sv | 95 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Used by fetch_queue and fetchq_storage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] next_addr;
    } fetchq_entry_t;

    localparam logic [31:0] FETCH_NOP = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction memory port, redirect/pop control, head outputs.
// master = queue side, slave = memory/decode/EX side.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Redirect;
    logic [31:0]   RedirectPC;
    logic          Pop;
    logic [31:0]   IM_Addr;
    logic [31:0]   IM_Data;
    logic          Out_Valid;
    logic [31:0]   Out_Instruction;
    logic [31:0]   Out_NextAddress;
    logic [CW-1:0] Count;

    modport master (
        input  Redirect, RedirectPC, Pop, IM_Data,
        output IM_Addr, Out_Valid, Out_Instruction,
        output Out_NextAddress, Count
    );

    modport slave (
        output Redirect, RedirectPC, Pop, IM_Data,
        input  IM_Addr, Out_Valid, Out_Instruction,
        input  Out_NextAddress, Count
    );

endinterface

// File: rtl/fetchq_storage.sv
// Entry array for the fetch queue: one write port, one async read port.
// Entries are not reset; validity is tracked by the queue count.
module fetchq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetchq_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetchq_entry_t rdata
);

    fetchq_entry_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and IF/ID.
// Optional same-cycle fetch-to-head bypass: define FETCHQ_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          Clk,
    input  logic          Reset,
    fetch_queue_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fpc;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic          q_valid;
    logic          pop_q;
    logic          push;
    logic          byp_take;
    fetchq_entry_t wdata;
    fetchq_entry_t head;

    assign q_valid = (count != '0);

`ifdef FETCHQ_BYPASS_EN
    logic byp_valid;
    // Gated by reset so the head reads as empty while held in reset.
    assign byp_valid = !q_valid && !bus.Redirect && Reset;
    assign byp_take  = byp_valid && bus.Pop;
`else
    assign byp_take  = 1'b0;
`endif

    assign pop_q = bus.Pop && q_valid && !bus.Redirect;
    assign push  = !bus.Redirect && (count != FULL || pop_q) && !byp_take;

    assign wdata = '{instr: bus.IM_Data, next_addr: fpc + PC_STEP};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fpc   <= RESET_PC;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (bus.Redirect) begin
            fpc   <= bus.RedirectPC;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push || byp_take) fpc <= fpc + PC_STEP;
            if (push)             wptr <= wptr + 1'b1;
            if (pop_q)            rptr <= rptr + 1'b1;
            if (push && !pop_q)
                count <= count + 1'b1;
            else if (pop_q && !push)
                count <= count - 1'b1;
        end
    end

    fetchq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .Clk   (Clk),
        .we    (push),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (head)
    );

    always_comb begin
        bus.Out_Valid       = q_valid;
        bus.Out_Instruction = q_valid ? head.instr     : FETCH_NOP;
        bus.Out_NextAddress = q_valid ? head.next_addr : 32'h0;
`ifdef FETCHQ_BYPASS_EN
        if (byp_valid) begin
            bus.Out_Valid       = 1'b1;
            bus.Out_Instruction = bus.IM_Data;
            bus.Out_NextAddress = fpc + PC_STEP;
        end
`endif
    end

    assign bus.IM_Addr = fpc;
    assign bus.Count   = count;

endmodule
